xbus_select_sequencer: RTL and testbench

Bus-cycle sequencer that sits directly upstream of the 3-to-8 device-select decoder on the Xbus I/O path. It accepts a single-cycle request carrying a 3-bit device code. It then drives the decoder's select code {C,B,A} and its enables (G1, G2A_n, G2B_n) through a timed sequence: address setup, strobe, wait for acknowledge, hold. It reports completion or timeout to the requesting microcode-side logic.

---
 rtl/xbus_pkg.sv | 19 +
 rtl/xbus_sel_timer.sv | 34 +++
 rtl/xbus_select_sequencer.sv | 151 +++++++++++++++
 tb/tb_xbus_select_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared definitions for the Xbus select sequencer.
// - state_t   : sequencer state encoding (IDLE=0 .. HOLD=4, 3 bits)
// - DEF_*     : default bus-cycle timing constants
package xbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_TIMEOUT       = 255;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/xbus_sel_timer.sv
// Loadable saturating down-counter used to time SETUP, STROBE and WAIT_ACK.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force count to zero (highest priority after reset)
//   load       : load load_val
//   load_val   : value giving (duration - 1) cycles
//   tc         : terminal count, high when count is zero
module xbus_sel_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;   // saturate at zero
    end

    assign tc = (count == '0);

endmodule

// File: rtl/xbus_select_sequencer.sv
// Bus-cycle sequencer feeding the 3-to-8 device-select decoder.
// Runs SETUP -> STROBE -> (WAIT_ACK) -> HOLD for each accepted request and
// pulses done (with timeout_err on abort) in the first IDLE cycle after HOLD.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req/req_addr/req_write : single-cycle request, sampled only in IDLE
//   inhibit             : global select inhibit, registered onto g2b_n
//   ack                 : device acknowledge
//   busy, done, timeout_err, wr : status to microcode side
//   sel, g1, g2a_n, g2b_n : decoder select code and enables
module xbus_select_sequencer
    import xbus_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] req_addr,
    input  logic       req_write,
    input  logic       inhibit,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       wr,
    output logic [2:0] sel,
    output logic       g1,
    output logic       g2a_n,
    output logic       g2b_n
);

    // Timer is loaded with (duration - 1) on state entry; tc marks the last cycle.
    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic             t_clear, t_load, t_tc;
    logic [CNT_W-1:0] t_load_val;
    logic             start, set_err;
    logic             ack_seen, err;

    xbus_sel_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (t_clear),
        .load     (t_load),
        .load_val (t_load_val),
        .tc       (t_tc)
    );

    always_comb begin
        next_state = state;
        t_clear    = 1'b0;
        t_load     = 1'b0;
        t_load_val = '0;
        start      = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    start      = 1'b1;
                    next_state = ST_SETUP;
                    t_load     = 1'b1;
                    t_load_val = SETUP_LOAD;
                end else begin
                    t_clear = 1'b1;
                end
            end
            ST_SETUP: begin
                if (t_tc) begin
                    next_state = ST_STROBE;
                    t_load     = 1'b1;
                    t_load_val = STROBE_LOAD;
                end
            end
            ST_STROBE: begin
                if (t_tc) begin
                    // ack on any strobe edge, including this final one, skips WAIT_ACK
                    if (ack_seen || ack) begin
                        next_state = ST_HOLD;
                    end else begin
                        next_state = ST_WAIT_ACK;
                        t_load     = 1'b1;
                        t_load_val = TIMEOUT_LOAD;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // ack wins over a coincident timeout expiry
                if (ack) begin
                    next_state = ST_HOLD;
                end else if (t_tc) begin
                    next_state = ST_HOLD;
                    set_err    = 1'b1;
                end
            end
            ST_HOLD: begin
                next_state = ST_IDLE;
                t_clear    = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
                t_clear    = 1'b1;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            wr          <= 1'b0;
            sel         <= 3'd0;
            g1          <= 1'b0;
            g2a_n       <= 1'b1;
            g2b_n       <= 1'b1;
            ack_seen    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state != ST_IDLE);
            g1          <= (next_state != ST_IDLE);
            g2a_n       <= !((next_state == ST_STROBE) || (next_state == ST_WAIT_ACK));
            done        <= (state == ST_HOLD);
            timeout_err <= (state == ST_HOLD) && err;
            g2b_n       <= inhibit;
            ack_seen    <= (state == ST_STROBE) ? (ack_seen | ack) : 1'b0;

            if (start) begin
                sel <= req_addr;
                wr  <= req_write;
            end else if (next_state == ST_IDLE) begin
                wr  <= 1'b0;
            end

            if (start)
                err <= 1'b0;
            else if (set_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xbus_select_sequencer.sv
// Directed bench for xbus_select_sequencer: one default-timing instance (a)
// and one with TIMEOUT=4 (b) for the abort and ack-at-expiry cases.
module tb_xbus_select_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, ack_a, req_b, ack_b;
    logic [2:0] req_addr;
    logic       req_write, inhibit;

    logic       busy_a, done_a, terr_a, wr_a, g1_a, g2a_n_a, g2b_n_a;
    logic [2:0] sel_a;
    logic       busy_b, done_b, terr_b, wr_b, g1_b, g2a_n_b, g2b_n_b;
    logic [2:0] sel_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xbus_select_sequencer u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_addr(req_addr),
        .req_write(req_write), .inhibit(inhibit), .ack(ack_a),
        .busy(busy_a), .done(done_a), .timeout_err(terr_a), .wr(wr_a),
        .sel(sel_a), .g1(g1_a), .g2a_n(g2a_n_a), .g2b_n(g2b_n_a)
    );

    xbus_select_sequencer #(.TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_addr(req_addr),
        .req_write(req_write), .inhibit(inhibit), .ack(ack_b),
        .busy(busy_b), .done(done_b), .timeout_err(terr_b), .wr(wr_b),
        .sel(sel_b), .g1(g1_b), .g2a_n(g2a_n_b), .g2b_n(g2b_n_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b0; ack_a = 1'b0; req_b = 1'b0; ack_b = 1'b0;
        req_addr = 3'd0; req_write = 1'b0; inhibit = 1'b0;

        // reset state
        #2;
        chk("rst busy",  busy_a,  0);
        chk("rst done",  done_a,  0);
        chk("rst terr",  terr_a,  0);
        chk("rst wr",    wr_a,    0);
        chk("rst sel",   sel_a,   0);
        chk("rst g1",    g1_a,    0);
        chk("rst g2a_n", g2a_n_a, 1);
        chk("rst g2b_n", g2b_n_a, 1);
        tick();
        reset = 1'b0;
        tick();
        chk("idle g2b_n", g2b_n_a, 0);

        // basic write, ack tied high
        req_addr = 3'd5; req_write = 1'b1; ack_a = 1'b1; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        chk("t1 c1 busy",  busy_a,  1);
        chk("t1 c1 g1",    g1_a,    1);
        chk("t1 c1 g2a_n", g2a_n_a, 1);
        chk("t1 c1 sel",   sel_a,   5);
        chk("t1 c1 wr",    wr_a,    1);
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk($sformatf("t1 c%0d g2a_n", c), g2a_n_a, (c == 2 || c == 3) ? 8'd0 : 8'd1);
            chk($sformatf("t1 c%0d done", c), done_a, (c == 5) ? 8'd1 : 8'd0);
            chk($sformatf("t1 c%0d busy", c), busy_a, (c <= 4) ? 8'd1 : 8'd0);
            chk($sformatf("t1 c%0d wr", c), wr_a, (c <= 4) ? 8'd1 : 8'd0);
            chk($sformatf("t1 c%0d terr", c), terr_a, 0);
            if (c <= 4) chk($sformatf("t1 c%0d sel", c), sel_a, 5);
        end

        // one-cycle ack during first STROBE cycle is remembered
        ack_a = 1'b0; req_addr = 3'd3; req_write = 1'b0; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        chk("t2 c3 g2a_n", g2a_n_a, 0);
        tick();
        chk("t2 c4 g2a_n", g2a_n_a, 1);
        chk("t2 c4 busy",  busy_a,  1);
        chk("t2 c4 sel",   sel_a,   3);
        chk("t2 c4 wr",    wr_a,    0);
        tick();
        chk("t2 c5 done",  done_a,  1);
        chk("t2 c5 terr",  terr_a,  0);
        tick();
        chk("t2 c6 done",  done_a,  0);

        // reset in the middle of STROBE
        req_addr = 3'd7; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        chk("t3 strobe g2a_n", g2a_n_a, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t3 async g2a_n", g2a_n_a, 1);
        chk("t3 async g1",    g1_a,    0);
        chk("t3 async busy",  busy_a,  0);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("t3 post%0d done", c), done_a, 0);
            chk($sformatf("t3 post%0d g2a_n", c), g2a_n_a, 1);
        end
        ack_a = 1'b1; req_addr = 3'd1; req_write = 1'b1; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        chk("t3 rerun sel",  sel_a,  1);
        chk("t3 rerun busy", busy_a, 1);
        repeat (4) tick();
        chk("t3 rerun done", done_a, 1);
        tick();

        // back-to-back with req held, addr alternating
        req_addr = 3'd2; req_write = 1'b0; req_a = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk($sformatf("t4 c%0d done", c), done_a, (c % 5 == 0) ? 8'd1 : 8'd0);
            chk($sformatf("t4 c%0d busy", c), busy_a, (c % 5 == 0) ? 8'd0 : 8'd1);
            if (c % 5 != 0)
                chk($sformatf("t4 c%0d sel", c), sel_a, ((c / 5) % 2 == 0) ? 8'd2 : 8'd6);
            if (c == 2)  req_addr = 3'd6;
            if (c == 7)  req_addr = 3'd2;
            if (c == 12) req_addr = 3'd6;
            if (c == 14) req_a = 1'b0;
        end
        tick();
        chk("t4 stop busy", busy_a, 0);

        // inhibit in IDLE
        inhibit = 1'b1;
        chk("t5 idle g2b_n pre", g2b_n_a, 0);
        tick();
        chk("t5 idle g2b_n hi", g2b_n_a, 1);
        inhibit = 1'b0;
        tick();
        chk("t5 idle g2b_n lo", g2b_n_a, 0);
        // inhibit mid-sequence does not stall
        req_addr = 3'd4; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        inhibit = 1'b1;
        chk("t5 c2 g2a_n", g2a_n_a, 0);
        tick();
        chk("t5 c3 g2b_n", g2b_n_a, 1);
        chk("t5 c3 g2a_n", g2a_n_a, 0);
        inhibit = 1'b0;
        tick();
        chk("t5 c4 g2b_n", g2b_n_a, 0);
        chk("t5 c4 g2a_n", g2a_n_a, 1);
        chk("t5 c4 busy",  busy_a,  1);
        tick();
        chk("t5 c5 done",  done_a,  1);

        // TIMEOUT=4, no ack: abort with error
        req_addr = 3'd5; req_write = 1'b1; req_b = 1'b1;
        tick();
        req_b = 1'b0;
        chk("t6 c1 busy", busy_b, 1);
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk($sformatf("t6 c%0d g2a_n", c), g2a_n_b, (c <= 7) ? 8'd0 : 8'd1);
            chk($sformatf("t6 c%0d busy", c), busy_b, (c <= 8) ? 8'd1 : 8'd0);
            chk($sformatf("t6 c%0d done", c), done_b, (c == 9) ? 8'd1 : 8'd0);
            chk($sformatf("t6 c%0d terr", c), terr_b, (c == 9) ? 8'd1 : 8'd0);
        end

        // ack on the exact expiry edge counts as ack
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk($sformatf("t7 c%0d g2a_n", c), g2a_n_b, (c <= 7) ? 8'd0 : 8'd1);
            chk($sformatf("t7 c%0d done", c), done_b, (c == 9) ? 8'd1 : 8'd0);
            chk($sformatf("t7 c%0d terr", c), terr_b, 0);
            ack_b = (c == 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
